// File: rtl/rcon_sequencer.sv
// Sequential AES round-constant source for key-expansion / key-reversal engines.
//
// After an accepted start it presents the full Rcon sequence, one value per
// valid/ready handshake. Forward mode walks 0x01 upward (x2 in GF(2^8)).
// Reverse mode walks down from RCON_LAST (x0x8d, i.e. x2^-1).
//
// Ports:
//   clk        - clock, all logic on rising edge
//   rst        - synchronous active-high reset, highest priority
//   start      - request a new sequence, honoured only when idle
//   mode       - captured with an accepted start: 0 forward, 1 reverse
//   rcon       - current round constant
//   rcon_idx   - FIPS-197 index of rcon (1..NRCON)
//   rcon_valid - rcon / rcon_idx / rcon_last are valid
//   rcon_ready - consumer accepts the current value
//   rcon_last  - current value is the final one of the sequence
//   busy       - high while active or done
//   done       - one-cycle pulse after the final handshake
module rcon_sequencer #(
  parameter int unsigned NK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  output logic [7:0] rcon,
  output logic [3:0] rcon_idx,
  output logic       rcon_valid,
  input  logic       rcon_ready,
  output logic       rcon_last,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NRCON = (4 * (NK + 7) - 1) / NK;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("rcon_sequencer: NK must be 4, 6 or 8");
  end

  // GF(2^8) helpers, reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] mul4(input logic [7:0] x);
    return xtime(xtime(x));
  endfunction

  function automatic logic [7:0] mul8(input logic [7:0] x);
    return xtime(xtime(xtime(x)));
  endfunction

  // x * 0x8d = x*128 ^ x*8 ^ x*4 ^ x; 0x8d is the inverse of 0x02.
  function automatic logic [7:0] mul_8d(input logic [7:0] x);
    return mul8(xtime(mul8(x))) ^ mul8(x) ^ mul4(x) ^ x;
  endfunction

  function automatic logic [7:0] pow2(input int unsigned n);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned i = 0; i < n; i++) begin
      r = xtime(r);
    end
    return r;
  endfunction

  localparam logic [7:0] RCON_LAST = pow2(NRCON - 1);
  localparam logic [3:0] IDX_LAST  = 4'(NRCON);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] rcon_q, rcon_d;
  logic [3:0] idx_q, idx_d;
  logic       mode_q, mode_d;

  logic       active;
  logic       hs;
  logic       last;

  assign active = (state_q == StActive);
  assign hs     = active & rcon_ready;
  // Decoded from registered state so rcon_last never depends on rcon_ready.
  assign last   = active & (mode_q ? (idx_q == 4'd1) : (idx_q == IDX_LAST));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StActive;
      StActive: if (hs && last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next values: load on accepted start, step on non-last handshake.
  always_comb begin
    rcon_d = rcon_q;
    idx_d  = idx_q;
    mode_d = mode_q;
    if (state_q == StIdle && start) begin
      mode_d = mode;
      rcon_d = mode ? RCON_LAST : 8'h01;
      idx_d  = mode ? IDX_LAST : 4'd1;
    end else if (hs && !last) begin
      rcon_d = mode_q ? mul_8d(rcon_q) : xtime(rcon_q);
      idx_d  = mode_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcon_q <= 8'h00;
      idx_q  <= 4'd0;
      mode_q <= 1'b0;
    end else begin
      rcon_q <= rcon_d;
      idx_q  <= idx_d;
      mode_q <= mode_d;
    end
  end

  // Outputs
  always_comb begin
    rcon       = rcon_q;
    rcon_idx   = idx_q;
    rcon_valid = active;
    rcon_last  = last;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
  end

endmodule
